// File: rtl/clk_switch_seq.sv
// Clock-source switch sequencer for the clkwiz control bit-field.
// Runs hold-reset / select / wait-lock / measure / bounds-check / release
// on each accepted start and reports done or a sticky error with a cause code.
module clk_switch_seq #(
  parameter int unsigned RESET_HOLD    = 16,
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned LOCK_TIMEOUT  = 1000000,
  parameter int unsigned FMEAS_CYCLES  = 100000,
  parameter int unsigned CAPTURE_DELAY = 8,
  parameter int unsigned CNT_MIN       = 99000,
  parameter int unsigned CNT_MAX       = 101000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        target_sel,
  input  logic        locked,
  input  logic [23:0] fmeas_count,
  output logic        sys_reset,
  output logic        clk_sel,
  output logic        fmeas_en,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [23:0] meas_count
);

  localparam int unsigned Max1 = (RESET_HOLD > SETTLE_CYCLES) ? RESET_HOLD : SETTLE_CYCLES;
  localparam int unsigned Max2 = (Max1 > LOCK_TIMEOUT) ? Max1 : LOCK_TIMEOUT;
  localparam int unsigned Max3 = (Max2 > FMEAS_CYCLES) ? Max2 : FMEAS_CYCLES;
  localparam int unsigned MaxCycles = (Max3 > CAPTURE_DELAY) ? Max3 : CAPTURE_DELAY;
  localparam int unsigned CntW = $clog2(MaxCycles + 1);

  localparam logic [23:0] CntMin = CNT_MIN[23:0];
  localparam logic [23:0] CntMax = CNT_MAX[23:0];

  localparam logic [1:0] ErrNone = 2'd0;
  localparam logic [1:0] ErrLock = 2'd1;
  localparam logic [1:0] ErrLow  = 2'd2;
  localparam logic [1:0] ErrHigh = 2'd3;

  typedef enum logic [3:0] {
    StIdle, StHold, StSettle, StWaitLock, StMeasure,
    StCapture, StCheck, StRelease, StDone, StFail
  } state_e;

  state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic        tgt_q, tgt_d;
  // start that arrived together with a lock loss in DONE; replayed from FAIL
  logic        pend_q, pend_d;
  logic        sys_reset_q, sys_reset_d;
  logic        clk_sel_q, clk_sel_d;
  logic        fmeas_en_q, fmeas_en_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [23:0] meas_count_q, meas_count_d;

  logic        accept;
  logic        go_fail;
  logic [1:0]  fail_code;

  // State and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      tgt_q        <= 1'b0;
      pend_q       <= 1'b0;
      sys_reset_q  <= 1'b1;
      clk_sel_q    <= 1'b0;
      fmeas_en_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      err_code_q   <= ErrNone;
      meas_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tgt_q        <= tgt_d;
      pend_q       <= pend_d;
      sys_reset_q  <= sys_reset_d;
      clk_sel_q    <= clk_sel_d;
      fmeas_en_q   <= fmeas_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      err_code_q   <= err_code_d;
      meas_count_q <= meas_count_d;
    end
  end

  // Next-state and registered-output logic; counter reloads to N-1 on state entry
  always_comb begin
    state_d      = state_q;
    cnt_d        = (cnt_q != '0) ? cnt_q - CntW'(1) : '0;
    tgt_d        = tgt_q;
    pend_d       = pend_q;
    sys_reset_d  = sys_reset_q;
    clk_sel_d    = clk_sel_q;
    fmeas_en_d   = fmeas_en_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    error_d      = error_q;
    err_code_d   = err_code_q;
    meas_count_d = meas_count_q;
    accept       = 1'b0;
    go_fail      = 1'b0;
    fail_code    = ErrNone;

    unique case (state_q)
      StIdle, StFail: accept = start | pend_q;
      StHold: begin
        if (cnt_q == '0) begin
          clk_sel_d = tgt_q;
          state_d   = StSettle;
          cnt_d     = CntW'(SETTLE_CYCLES - 1);
        end
      end
      StSettle: begin
        if (cnt_q == '0) begin
          state_d = StWaitLock;
          cnt_d   = CntW'(LOCK_TIMEOUT - 1);
        end
      end
      StWaitLock: begin
        // lock takes priority over an expiring timeout
        if (locked) begin
          state_d    = StMeasure;
          cnt_d      = CntW'(FMEAS_CYCLES - 1);
          fmeas_en_d = 1'b1;
        end else if (cnt_q == '0) begin
          go_fail   = 1'b1;
          fail_code = ErrLock;
        end
      end
      StMeasure: begin
        if (!locked) begin
          go_fail   = 1'b1;
          fail_code = ErrLock;
        end else if (cnt_q == '0) begin
          fmeas_en_d = 1'b0;
          state_d    = StCapture;
          cnt_d      = CntW'(CAPTURE_DELAY - 1);
        end
      end
      StCapture: begin
        if (cnt_q == '0) begin
          meas_count_d = fmeas_count;
          state_d      = StCheck;
        end
      end
      StCheck: begin
        if (meas_count_q < CntMin) begin
          go_fail   = 1'b1;
          fail_code = ErrLow;
        end else if (meas_count_q > CntMax) begin
          go_fail   = 1'b1;
          fail_code = ErrHigh;
        end else begin
          sys_reset_d = 1'b0;
          done_d      = 1'b1;
          state_d     = StRelease;
        end
      end
      StRelease: begin
        busy_d  = 1'b0;
        state_d = StDone;
      end
      StDone: begin
        if (!locked) begin
          go_fail   = 1'b1;
          fail_code = ErrLock;
          if (start) begin
            pend_d = 1'b1;
            tgt_d  = target_sel;
          end
        end else begin
          accept = start;
        end
      end
      default: state_d = StIdle;
    endcase

    if (go_fail) begin
      state_d     = StFail;
      sys_reset_d = 1'b1;
      fmeas_en_d  = 1'b0;
      busy_d      = 1'b0;
      error_d     = 1'b1;
      err_code_d  = fail_code;
    end

    if (accept) begin
      state_d     = StHold;
      cnt_d       = CntW'(RESET_HOLD - 1);
      tgt_d       = start ? target_sel : tgt_q;
      pend_d      = 1'b0;
      error_d     = 1'b0;
      err_code_d  = ErrNone;
      busy_d      = 1'b1;
      sys_reset_d = 1'b1;
      fmeas_en_d  = 1'b0;
    end
  end

  assign sys_reset  = sys_reset_q;
  assign clk_sel    = clk_sel_q;
  assign fmeas_en   = fmeas_en_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign err_code   = err_code_q;
  assign meas_count = meas_count_q;

endmodule

// File: tb/tb_clk_switch_seq.sv
// Directed self-checking bench for clk_switch_seq with shortened timing parameters.
module tb_clk_switch_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic        target_sel;
  logic        locked;
  logic [23:0] fmeas_count;
  logic        sys_reset;
  logic        clk_sel;
  logic        fmeas_en;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;
  logic [23:0] meas_count;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  logic fm_seen = 1'b0;

  clk_switch_seq #(
    .RESET_HOLD    (4),
    .SETTLE_CYCLES (8),
    .LOCK_TIMEOUT  (50),
    .FMEAS_CYCLES  (100),
    .CAPTURE_DELAY (2),
    .CNT_MIN       (90),
    .CNT_MAX       (110)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .target_sel  (target_sel),
    .locked      (locked),
    .fmeas_count (fmeas_count),
    .sys_reset   (sys_reset),
    .clk_sel     (clk_sel),
    .fmeas_en    (fmeas_en),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .err_code    (err_code),
    .meas_count  (meas_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; sample 1 time unit after the edge
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
      if (fmeas_en) fm_seen = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic tgt);
    target_sel = tgt;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Full run with locked held high; returns just after the CHECK decision edge
  task automatic run_seq(input logic tgt, input logic [23:0] fc);
    fmeas_count = fc;
    locked = 1'b1;
    do_start(tgt);
    chk("run_busy", 32'(busy), 32'd1);
    tick(4);
    chk("run_clk_sel", 32'(clk_sel), 32'(tgt));
    tick(9);
    chk("run_fmeas_on", 32'(fmeas_en), 32'd1);
    tick(100);
    chk("run_fmeas_off", 32'(fmeas_en), 32'd0);
    tick(3);
    chk("run_meas_count", 32'(meas_count), 32'(fc));
  endtask

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0;
    target_sel = 1'b0;
    locked = 1'b0;
    fmeas_count = 24'd0;
    tick(2);
    chk("rst_sys_reset", 32'(sys_reset), 32'd1);
    chk("rst_clk_sel", 32'(clk_sel), 32'd0);
    chk("rst_fmeas_en", 32'(fmeas_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    chk("rst_meas_count", 32'(meas_count), 32'd0);
    reset = 1'b0;
    tick(1);

    // 1: nominal switch to TCXO; a second start while busy must be ignored
    fmeas_count = 24'd100;
    done_cnt = 0;
    do_start(1'b1);
    chk("t1_busy", 32'(busy), 32'd1);
    tick(2);
    do_start(1'b0);
    chk("t1_clk_sel_e3", 32'(clk_sel), 32'd0);
    tick(1);
    chk("t1_clk_sel_e4", 32'(clk_sel), 32'd1);
    tick(10);
    chk("t1_no_fmeas_prelock", 32'(fmeas_en), 32'd0);
    locked = 1'b1;
    tick(1);
    chk("t1_fmeas_start", 32'(fmeas_en), 32'd1);
    n = 1;
    while (fmeas_en && n < 300) begin
      tick(1);
      if (fmeas_en) n++;
    end
    chk("t1_fmeas_width", 32'(n), 32'd100);
    tick(2);
    chk("t1_meas_count", 32'(meas_count), 32'd100);
    chk("t1_no_done_yet", 32'(done), 32'd0);
    tick(1);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_sys_reset_rel", 32'(sys_reset), 32'd0);
    tick(1);
    chk("t1_done_pulse", 32'(done), 32'd0);
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_error", 32'(error), 32'd0);
    chk("t1_done_count", 32'(done_cnt), 32'd1);

    // 4b: lock lost while in DONE
    locked = 1'b0;
    tick(1);
    chk("t4b_sys_reset", 32'(sys_reset), 32'd1);
    chk("t4b_error", 32'(error), 32'd1);
    chk("t4b_err_code", 32'(err_code), 32'd1);

    // 2: lock never arrives
    do_start(1'b1);
    fm_seen = 1'b0;
    chk("t2_err_cleared", 32'(error), 32'd0);
    chk("t2_code_cleared", 32'(err_code), 32'd0);
    tick(12);
    tick(49);
    chk("t2_not_yet", 32'(error), 32'd0);
    chk("t2_busy", 32'(busy), 32'd1);
    tick(1);
    chk("t2_error", 32'(error), 32'd1);
    chk("t2_err_code", 32'(err_code), 32'd1);
    chk("t2_sys_reset", 32'(sys_reset), 32'd1);
    chk("t2_busy_end", 32'(busy), 32'd0);
    chk("t2_fmeas_never", 32'(fm_seen), 32'd0);

    // 5b: recover from FAIL back to pl_clk0
    run_seq(1'b0, 24'd100);
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_error", 32'(error), 32'd0);
    chk("t5_clk_sel", 32'(clk_sel), 32'd0);
    tick(1);

    // 3: frequency bounds
    run_seq(1'b1, 24'd89);
    chk("t3_low_code", 32'(err_code), 32'd2);
    chk("t3_low_done", 32'(done), 32'd0);
    chk("t3_low_sysrst", 32'(sys_reset), 32'd1);
    run_seq(1'b1, 24'd111);
    chk("t3_high_code", 32'(err_code), 32'd3);
    chk("t3_high_error", 32'(error), 32'd1);
    run_seq(1'b1, 24'd90);
    chk("t3_min_done", 32'(done), 32'd1);
    chk("t3_min_code", 32'(err_code), 32'd0);
    tick(1);
    run_seq(1'b1, 24'd110);
    chk("t3_max_done", 32'(done), 32'd1);
    chk("t3_max_error", 32'(error), 32'd0);
    tick(1);

    // 4a: lock drops at MEASURE cycle 40
    do_start(1'b1);
    tick(13);
    tick(39);
    chk("t4a_fmeas_on", 32'(fmeas_en), 32'd1);
    locked = 1'b0;
    tick(1);
    chk("t4a_fmeas_off", 32'(fmeas_en), 32'd0);
    chk("t4a_err_code", 32'(err_code), 32'd1);
    chk("t4a_busy", 32'(busy), 32'd0);

    // start coincident with lock loss in DONE is replayed after FAIL
    run_seq(1'b1, 24'd100);
    tick(1);
    locked = 1'b0;
    do_start(1'b0);
    chk("pend_error", 32'(error), 32'd1);
    chk("pend_busy0", 32'(busy), 32'd0);
    locked = 1'b1;
    tick(1);
    chk("pend_busy1", 32'(busy), 32'd1);
    chk("pend_err_clear", 32'(error), 32'd0);
    tick(4);
    chk("pend_clk_sel", 32'(clk_sel), 32'd0);
    tick(112);
    chk("pend_done", 32'(done), 32'd1);
    tick(1);

    // 6: reset during MEASURE aborts; a fresh run then completes
    do_start(1'b1);
    tick(13);
    tick(20);
    chk("t6_in_measure", 32'(fmeas_en), 32'd1);
    reset = 1'b1;
    done_cnt = 0;
    tick(1);
    reset = 1'b0;
    chk("t6_sys_reset", 32'(sys_reset), 32'd1);
    chk("t6_clk_sel", 32'(clk_sel), 32'd0);
    chk("t6_fmeas_en", 32'(fmeas_en), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_meas_count", 32'(meas_count), 32'd0);
    tick(150);
    chk("t6_no_done", 32'(done_cnt), 32'd0);
    run_seq(1'b1, 24'd100);
    chk("t6_rerun_done", 32'(done), 32'd1);
    chk("t6_rerun_sysrst", 32'(sys_reset), 32'd0);
    tick(1);
    chk("t6_rerun_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
